instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage for the single-cycle RISC-V core. It sits directly upstream of `Reg_File`: it owns the program counter and issues word fetches to instruction memory over a request/grant/response handshake. It presents one registered `instruction` to decode/`Reg_File`, which slices the rs1/rs2/rd fields from it. It also takes branch/jump redirects from the execute path and flushes any fetch still in flight.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset; must be word-aligned.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; equals `pc_q`.
- `imem_gnt`  in  1  memory accepts the request this cycle; only meaningful while `imem_req`=1.
- `imem_rvalid`  in  1  response valid; arrives at least 1 cycle after the grant.
- `imem_rdata`  in  32  fetched instruction word.
- `redirect`  in  1  single-cycle pulse: fetch resumes at `redirect_pc`.
- `redirect_pc`  in  32  branch/jump target.
- `stall`  in  1  downstream cannot accept; holds `instruction`.
- `instr_valid`  out  1  `instruction` and `instr_pc` are valid.
- `instruction`  out  32  registered instruction word to decode/`Reg_File`.
- `instr_pc`  out  32  address of `instruction`.
- `pc_plus4`  out  32  `instr_pc` + 4, combinational, for JAL/JALR link.
- `misalign_fault`  out  1  redirect target not word-aligned; fetch halted.

## Operation
- Registers:
  - `pc_q`: next fetch address.
  - `req_pc`: address of the outstanding fetch.
  - `kill`: drop the next response.
  - `state`: one of FETCH, WAIT, FAULT.
  - Output registers: `instruction`, `instr_pc`, `instr_valid`.
- At most one fetch is outstanding.
- Consume: an instruction is consumed in any cycle with `instr_valid`=1 and `stall`=0. `instr_valid` clears on consume unless a new response loads the same cycle.
- Issue condition: (`instr_valid`=0 or `stall`=0). This guarantees the output register is empty when the response returns, so no skid buffer is needed.
- FETCH:
  - `imem_req` = issue condition AND NOT `redirect` (combinational gate).
  - On `imem_req` and `imem_gnt`: `req_pc`<=`pc_q`, `pc_q`<=`pc_q`+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0), go to WAIT.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid` with `kill`=0: load `instruction`<=`imem_rdata`, `instr_pc`<=`req_pc`, set `instr_valid`=1, go to FETCH.
  - On `imem_rvalid` with `kill`=1: discard the data, clear `kill`, go to FETCH.
- FAULT:
  - `imem_req`=0, `misalign_fault`=1, `instr_valid`=0.
  - Leave only on an aligned `redirect` (to FETCH) or on `rst`.
- `imem_rvalid` outside WAIT is ignored (covers stale responses after reset).
- Redirect, aligned (`redirect_pc[1:0]`=0). Priority over stall and over any issue that cycle:
  - `pc_q`<=`redirect_pc`.
  - `instr_valid`<=0 (flush, even if stalled).
  - In WAIT without `imem_rvalid` that cycle: `kill`<=1, stay in WAIT.
  - In WAIT with `imem_rvalid` that cycle: discard the response, go to FETCH.
  - In FETCH or FAULT: go to FETCH.
- Redirect, misaligned (`redirect_pc[1:0]`!=0):
  - Flush as for an aligned redirect.
  - In FETCH: go to FAULT.
  - In WAIT: set `kill`, go to FAULT once the response arrives and is dropped.
  - `misalign_fault` asserts the cycle after the redirect and stays high until it is cleared.
- `pc_plus4` = `instr_pc`+4, modulo 2^32.

## Timing
- Reset values:
  - `pc_q`=`RESET_PC`, state=FETCH.
  - `kill`=0, `req_pc`=0.
  - `instr_valid`=0, `instruction`=32'h0000_0013 (NOP), `instr_pc`=0, `misalign_fault`=0.
- `imem_req` is high in the first cycle after `rst` deasserts, with `imem_addr`=`RESET_PC`.
- Latency: grant in cycle N, `imem_rvalid` in cycle M≥N+1, then `instr_valid`=1 from cycle M+1.
  - With a 1-cycle memory and no stall: one instruction every 2 cycles.
  - Next request issues in cycle M+1, concurrent with the new `instr_valid`.
- Stall: `instruction`/`instr_pc` are stable while `instr_valid`=1 and `stall`=1; no new request is issued.
- Redirect in cycle R: `imem_req` is low in cycle R; the first request to `redirect_pc` issues in R+1 if not waiting.
- Asynchronous `rst` mid-WAIT: outputs go to reset values immediately; the outstanding response is ignored.

## Test plan
- Reset, `RESET_PC`=0, 1-cycle memory (grant always, rvalid next cycle), no stall:
  - addresses 0, 4, 8 requested on alternate cycles;
  - `instr_valid` high for one cycle each, with `instr_pc` 0, 4, 8 and matching data.
- `stall`=1 for 5 cycles while `instruction`=32'h00500093 (`instr_pc`=4):
  - outputs are held, `imem_req`=0;
  - after release, the fetch of 8 issues that cycle.
- `redirect` to 32'h100 while in WAIT for address 8, response arriving 2 cycles later:
  - the response for 8 is dropped, `instr_valid` stays 0;
  - next request is `imem_addr`=32'h100, and `instr_pc`=32'h100 follows.
- `redirect` to 32'h102:
  - `misalign_fault`=1 and `imem_req`=0 for 10 cycles;
  - then `redirect` to 32'h200 clears the fault and fetches 32'h200.
- Async `rst` pulse mid-WAIT, with a stale `imem_rvalid` one cycle after release:
  - outputs reset immediately;
  - the stale response is ignored, and a fresh fetch to `RESET_PC` follows.
- `pc_q`=32'hFFFF_FFFC fetched, then next `imem_addr`=0 (wrap), and `pc_plus4` for that instruction = 0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word fetches
// over a req/gnt/rvalid handshake and presents one registered instruction.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int unsigned XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            instr_valid,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign_fault
);
    localparam logic [XLEN-1:0] NOP    = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] WORD_B = XLEN'(4);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc, req_pc_d;
    logic            kill, kill_d;
    logic [XLEN-1:0] instr_d, ipc_d;
    logic            valid_d, fault_d;
    logic            issue;
    logic            misaligned;

    assign imem_addr  = pc_q;
    assign pc_plus4   = instr_pc + WORD_B;
    assign issue      = !instr_valid || !stall;
    assign misaligned = |redirect_pc[1:0];

    // Next-state and fetch handshake; redirect overrides everything else.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc;
        kill_d   = kill;
        instr_d  = instruction;
        ipc_d    = instr_pc;
        valid_d  = instr_valid && stall;
        fault_d  = misalign_fault;
        imem_req = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = issue && !redirect;
                if (imem_req && imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + WORD_B;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (!kill && !redirect) begin
                        instr_d = imem_rdata;
                        ipc_d   = req_pc;
                        valid_d = 1'b1;
                    end
                    kill_d  = 1'b0;
                    // a misaligned redirect seen while waiting halts once the response drains
                    state_d = misalign_fault ? S_FAULT : S_FETCH;
                end
            end
            S_FAULT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (redirect) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            fault_d = misaligned;
            if (state_q == S_WAIT && !imem_rvalid) begin
                kill_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                kill_d  = 1'b0;
                state_d = misaligned ? S_FAULT : S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_FETCH;
            pc_q           <= RESET_PC;
            req_pc         <= '0;
            kill           <= 1'b0;
            instruction    <= NOP;
            instr_pc       <= '0;
            instr_valid    <= 1'b0;
            misalign_fault <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            req_pc         <= req_pc_d;
            kill           <= kill_d;
            instruction    <= instr_d;
            instr_pc       <= ipc_d;
            instr_valid    <= valid_d;
            misalign_fault <= fault_d;
        end
    end

endmodule
